// File: rtl/mem_readback.sv
// Streams len words from a 1-cycle-latency memory read port onto a valid/ready
// output, holding at most two words between in-flight reads and a 2-entry FIFO.
module mem_readback #(
    parameter int WID_MEM   = 32,
    parameter int DEPTH_MEM = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        start_addr,
    input  logic [31:0]        len,
    output logic [31:0]        raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic [WID_MEM-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam logic [31:0] ADDR_MASK = 32'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         left_q, left_d;
    logic [31:0]         raddr_q, raddr_d;
    logic                infl_q, infl_d;
    logic                infl_last_q, infl_last_d;
    logic                done_q, done_d;

    logic [WID_MEM-1:0]  fdata_q [2];
    logic                flast_q [2];
    logic                wptr_q;
    logic                rptr_q;
    logic [1:0]          cnt_q;

    logic                push;
    logic                pop;
    logic                issue;
    logic [2:0]          occ;

    assign push      = infl_q;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = fdata_q[rptr_q];
    assign out_last  = out_valid & flast_q[rptr_q];
    assign raddr     = raddr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Occupancy counted after this cycle's transfer, so a steady stream keeps 1 word/clk.
    assign occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue = (state_q == RUN) && (occ < 3'd2);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        raddr_d     = raddr_q;
        done_d      = 1'b0;
        infl_d      = issue;
        infl_last_d = issue && (left_q == 32'd1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = start_addr & ADDR_MASK;
                    left_d = len;
                    if (len == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    raddr_d = addr_q;
                    addr_d  = (addr_q + 32'd1) & ADDR_MASK;
                    left_d  = left_q - 32'd1;
                    if (left_q == 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && flast_q[rptr_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            left_q      <= 32'd0;
            raddr_q     <= 32'd0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            raddr_q     <= raddr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    // Capture stage: the word addressed last cycle lands in the output FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                flast_q[i] <= 1'b0;
            end
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                fdata_q[wptr_q] <= rdata;
                flast_q[wptr_q] <= infl_last_q;
                wptr_q          <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: doc/mem_readback.md
MEM_READBACK -- requirements
Module: mem_readback

Interface
- REQ-001 The block SHALL have parameter WID_MEM, default 32: data word width, equal to the width of the attached memory.
- REQ-002 The block SHALL have parameter DEPTH_MEM, default 512: attached memory depth; it is a power of two.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a readback.
- REQ-006 The block SHALL have port start_addr, input, 32 bits: first word address, sampled when start is accepted.
- REQ-007 The block SHALL have port len, input, 32 bits: number of words to read, sampled when start is accepted.
- REQ-008 The block SHALL have port raddr, output, 32 bits: read address to the memory read port.
- REQ-009 The block SHALL have port rdata, input, WID_MEM bits: memory read data, valid exactly one clk after the matching raddr.
- REQ-010 The block SHALL have port out_data, output, WID_MEM bits: stream data.
- REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
- REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
- REQ-013 The block SHALL have port out_last, output, 1 bit: qualifies the final word of a readback.
- REQ-014 The block SHALL have port busy, output, 1 bit: a readback is in progress.
- REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a readback completes.

Function
- REQ-016 The block SHALL implement the states IDLE, RUN and DRAIN.
- REQ-017 In IDLE, start=1 SHALL latch start_addr and len; with len!=0 the next state SHALL be RUN, and with len=0 the block SHALL stay in IDLE and pulse done on the next cycle without emitting any beat.
- REQ-018 start SHALL be ignored while busy=1.
- REQ-019 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.
- REQ-020 The i-th read (i = 0..len-1) SHALL present raddr = (start_addr + i) mod DEPTH_MEM, with upper raddr bits zero.
- REQ-021 Addresses SHALL wrap from DEPTH_MEM-1 to 0.
- REQ-022 The read issue rule SHALL be: a read is issued in a cycle only if (words in output buffer + reads in flight) < 2.
- REQ-023 rdata SHALL be captured one cycle after issue into a 2-entry output FIFO, so no word is ever dropped or duplicated under any out_ready pattern.
- REQ-024 When out_ready is held at 1, a word SHALL be issued every cycle, for a throughput of 1 word/clk.
- REQ-025 The first out_valid SHALL occur 2 clks after the start-accepted edge (edge 0: raddr issued at edge 1, out_valid from edge 2).
- REQ-026 A beat SHALL transfer when out_valid and out_ready are both 1.
- REQ-027 Once asserted, out_valid SHALL stay asserted, with out_data and out_last stable, until the beat transfers.
- REQ-028 out_last SHALL be 1 only on the len-th beat.
- REQ-029 RUN SHALL go to DRAIN after the len-th read is issued.
- REQ-030 DRAIN SHALL go to IDLE on the cycle the last beat transfers, and done SHALL pulse 1 on the following cycle, coincident with busy=0.
- REQ-031 The word counters SHALL be 32 bits wide, and len up to 2^32-1 SHALL be honoured; len > DEPTH_MEM re-reads wrapped addresses.
- REQ-032 raddr SHALL hold its last value when no read is issued.

Reset
- REQ-033 While reset=0, the block SHALL asynchronously force state=IDLE, raddr=0, out_valid=0, out_last=0, out_data=0, busy=0 and done=0, and SHALL clear the FIFO and in-flight tracking.
- REQ-034 If reset is asserted mid-readback, the readback SHALL be abandoned with no done pulse.
- REQ-035 After reset deasserts, the block SHALL accept start on the first clk edge.

Verification
- REQ-036 Basic read: memory preloaded with word k = k; start_addr=0, len=4, out_ready=1 -> beats 0,1,2,3 on consecutive clks, first at edge 2, out_last on value 3, done one clk after.
- REQ-037 Address wrap: DEPTH_MEM=512, start_addr=510, len=4 -> raddr sequence 510,511,0,1 and data 510,511,0,1.
- REQ-038 Backpressure: len=8 with out_ready toggling 1,0,0,1,... randomly -> all 8 words in order, no duplicates, out_data stable while stalled, at most 2 reads outstanding.
- REQ-039 Zero length: len=0 -> no out_valid, done pulses the next clk, busy stays 0.
- REQ-040 Start while busy: a second start mid-run with different start_addr/len -> ignored; the original sequence completes unaltered.
- REQ-041 Reset mid-run: reset=0 after 3 beats of a len=10 readback -> all outputs 0 immediately, no done pulse; a new start after release runs normally.
